io_bus_bridge: RTL and testbench
================================

Name: io_bus_bridge

Overview:
- Sits between the per-core I/O request ports and the shared non-cached I/O bus (peripheral register access).
- Round-robin arbitrates ioreq packets from NUM_CORES cores and issues one transaction at a time as a single-cycle write_en or read_en strobe.
- Captures read data one cycle after read_en and returns an iorsp packet (core, thread_idx, read_value) broadcast to all cores.
- Strictly one transaction in flight.

Parameters:
- NUM_CORES, 1, number of requesting cores (1..16; core id carried as 4-bit core_id_t).
- THREADS_PER_CORE, 4, threads per core; TIDW = $clog2(THREADS_PER_CORE).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ioreq_valid  in  NUM_CORES  per-core request valid.
- ioreq_store  in  NUM_CORES  1=store, 0=load.
- ioreq_thread_idx  in  NUM_CORES*TIDW  requesting local thread.
- ioreq_address  in  NUM_CORES*32  bus address.
- ioreq_value  in  NUM_CORES*32  store data.
- ioreq_ack  out  NUM_CORES  one-cycle pulse: request consumed.
- iorsp_valid  out  1  one-cycle response pulse.
- iorsp_core  out  4  core id of the completed request.
- iorsp_thread_idx  out  TIDW  thread of the completed request.
- iorsp_read_value  out  32  load data; 0 for stores.
- io_write_en  out  1  bus write strobe.
- io_read_en  out  1  bus read strobe.
- io_address  out  32  bus address.
- io_write_data  out  32  bus write data.
- io_read_data  in  32  bus read data, valid the cycle after io_read_en.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, rr_ptr=0.
  - All outputs 0; latched request fields 0.
  - Reset mid-transaction aborts it: no ack or response is produced afterwards.
- All outputs are registered.
- FSM IDLE:
  - If any ioreq_valid is set, grant the first set bit searching from rr_ptr upward with wrap-around.
  - Latch core, store, thread_idx, address and value of the granted core.
  - rr_ptr <= (grant+1) mod NUM_CORES; next state ISSUE.
  - No valid: stay in IDLE, rr_ptr unchanged.
- FSM ISSUE (one cycle):
  - io_write_en=store, io_read_en=~store, io_address and io_write_data from the latch.
  - ioreq_ack[grant]=1.
  - Next state: WAIT_READ for a load, RESPOND for a store.
- FSM WAIT_READ (one cycle):
  - Sample io_read_data into the response data register.
  - Next state RESPOND.
- FSM RESPOND (one cycle):
  - iorsp_valid=1 with the latched core, thread_idx and read_value (0 for a store).
  - Next state IDLE.
- Strobes and responses:
  - io_write_en and io_read_en are never both 1 and are 0 outside ISSUE.
  - io_address and io_write_data may hold stale values when both strobes are 0.
  - There is no response backpressure.
- Latency, with valid first seen in IDLE at cycle N:
  - Strobe and ack at N+1.
  - Store: iorsp_valid at N+2.
  - Load: read data sampled at N+2, iorsp_valid at N+3.
  - Back-to-back throughput is one store per 3 cycles, one load per 4 cycles.
- Requester rules:
  - Hold valid and all fields stable until ack.
  - Deasserting valid before ack is illegal (bench asserts).
  - The requester must drop or replace valid in the cycle after ack. A valid still asserted in the following IDLE cycle is treated as a new request.
- Simultaneous requests: exactly one grant per IDLE visit. Losers keep valid high and are served in rotation; no core starves. Worst-case wait is NUM_CORES-1 transactions.
- Single core (NUM_CORES=1): rr_ptr stays 0 and the grant is always core 0.

Test Plan:
- After reset with no requests -> all outputs 0, FSM idles indefinitely, no strobes.
- Core 0 thread 2 store, addr 0x0000_0040, value 0xDEADBEEF:
  - io_write_en=1, io_address=0x40, io_write_data=0xDEADBEEF at N+1, with ioreq_ack[0]=1.
  - iorsp_valid at N+2: core 0, thread 2, read_value 0.
- Core 1 thread 3 load, addr 0x0000_0080, bus returns 0x1234_5678 the cycle after read_en:
  - io_read_en at N+1.
  - iorsp_valid at N+3: core 1, thread 3, read_value 0x12345678.
- NUM_CORES=4, all cores issue loads simultaneously and hold valid -> grants in order 0,1,2,3, each response 4 cycles apart. A re-request from core 0 during this sequence is served after core 3.
- Assert reset during WAIT_READ of a load -> outputs clear immediately and no iorsp_valid follows. A store issued after reset release completes with normal latency.
- Randomized mix of stores and loads from 4 cores -> write_en and read_en never overlap, every ack is matched by exactly one response with the correct core/thread, and no request waits more than 3 other transactions.

Source files
------------

// File: rtl/io_bus_bridge.sv
// io_bus_bridge: round-robin arbiter between per-core I/O request ports and the
// shared non-cached peripheral bus. It keeps one transaction in flight, drives
// single-cycle bus strobes and broadcasts a response packet when the access is done.
module io_bus_bridge #(
  parameter int NUM_CORES        = 1,
  parameter int THREADS_PER_CORE = 4,
  localparam int TIDW = (THREADS_PER_CORE > 1) ? $clog2(THREADS_PER_CORE) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CORES-1:0]      ioreq_valid,
  input  logic [NUM_CORES-1:0]      ioreq_store,
  input  logic [NUM_CORES*TIDW-1:0] ioreq_thread_idx,
  input  logic [NUM_CORES*32-1:0]   ioreq_address,
  input  logic [NUM_CORES*32-1:0]   ioreq_value,
  output logic [NUM_CORES-1:0]      ioreq_ack,
  output logic                      iorsp_valid,
  output logic [3:0]                iorsp_core,
  output logic [TIDW-1:0]           iorsp_thread_idx,
  output logic [31:0]               iorsp_read_value,
  output logic                      io_write_en,
  output logic                      io_read_en,
  output logic [31:0]               io_address,
  output logic [31:0]               io_write_data,
  input  logic [31:0]               io_read_data
);

  localparam int          PW   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [PW:0] NC_W = (PW + 1)'(NUM_CORES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_READ,
    S_RESPOND
  } state_e;

  state_e                 state_q, state_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [3:0]             core_q, core_d;
  logic                   store_q, store_d;
  logic [TIDW-1:0]        tid_q, tid_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [NUM_CORES-1:0]   ack_q, ack_d;
  logic                   wr_en_q, wr_en_d;
  logic                   rd_en_q, rd_en_d;
  logic                   rsp_valid_q, rsp_valid_d;

  logic                   grant_found;
  logic [PW-1:0]          grant_idx;
  logic [PW:0]            cand;
  logic [PW:0]            rr_inc;
  logic [PW-1:0]          rr_next;

  // Round-robin search: first valid core at or after rr_ptr, wrapping around.
  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = {1'b0, rr_ptr_q} + (PW + 1)'(i);
      if (cand >= NC_W) cand = cand - NC_W;
      if (!grant_found && ioreq_valid[cand[PW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PW-1:0];
      end
    end
  end

  // Pointer that follows the granted core, wrapping at NUM_CORES.
  always_comb begin
    rr_inc  = {1'b0, grant_idx} + (PW + 1)'(1);
    rr_next = (rr_inc == NC_W) ? '0 : rr_inc[PW-1:0];
  end

  // Next-state and next-output logic; every output register reflects the state being entered.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    core_d      = core_q;
    store_d     = store_q;
    tid_d       = tid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ack_d       = '0;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    rsp_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          core_d           = 4'(grant_idx);
          store_d          = ioreq_store[grant_idx];
          tid_d            = ioreq_thread_idx[grant_idx*TIDW +: TIDW];
          addr_d           = ioreq_address[grant_idx*32 +: 32];
          wdata_d          = ioreq_value[grant_idx*32 +: 32];
          rdata_d          = '0;
          ack_d[grant_idx] = 1'b1;
          wr_en_d          = ioreq_store[grant_idx];
          rd_en_d          = ~ioreq_store[grant_idx];
          rr_ptr_d         = rr_next;
          state_d          = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (store_q) begin
          rsp_valid_d = 1'b1;
          state_d     = S_RESPOND;
        end else begin
          state_d = S_WAIT_READ;
        end
      end
      S_WAIT_READ: begin
        rdata_d     = io_read_data;
        rsp_valid_d = 1'b1;
        state_d     = S_RESPOND;
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State, request latch and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      core_q      <= '0;
      store_q     <= 1'b0;
      tid_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ack_q       <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      core_q      <= core_d;
      store_q     <= store_d;
      tid_q       <= tid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign ioreq_ack        = ack_q;
  assign io_write_en      = wr_en_q;
  assign io_read_en       = rd_en_q;
  assign io_address       = addr_q;
  assign io_write_data    = wdata_q;
  assign iorsp_valid      = rsp_valid_q;
  assign iorsp_core       = core_q;
  assign iorsp_thread_idx = tid_q;
  assign iorsp_read_value = rdata_q;

endmodule

// File: tb/tb_io_bus_bridge.sv
// Testbench for io_bus_bridge with four cores: a timeline model predicts every
// slot's outputs from the arbitration and latency rules, a compare process checks
// the DUT against it each cycle, and directed sections pin literal expectations.
module tb_io_bus_bridge;

  localparam int NC   = 4;
  localparam int TPC  = 4;
  localparam int TIDW = 2;
  localparam int MAXC = 4096;
  localparam int QD   = 64;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NC-1:0]        ioreq_valid;
  logic [NC-1:0]        ioreq_store;
  logic [NC*TIDW-1:0]   ioreq_thread_idx;
  logic [NC*32-1:0]     ioreq_address;
  logic [NC*32-1:0]     ioreq_value;
  logic [NC-1:0]        ioreq_ack;
  logic                 iorsp_valid;
  logic [3:0]           iorsp_core;
  logic [TIDW-1:0]      iorsp_thread_idx;
  logic [31:0]          iorsp_read_value;
  logic                 io_write_en;
  logic                 io_read_en;
  logic [31:0]          io_address;
  logic [31:0]          io_write_data;
  logic [31:0]          io_read_data;

  io_bus_bridge #(.NUM_CORES(NC), .THREADS_PER_CORE(TPC)) dut (
    .clk              (clk),
    .reset            (reset),
    .ioreq_valid      (ioreq_valid),
    .ioreq_store      (ioreq_store),
    .ioreq_thread_idx (ioreq_thread_idx),
    .ioreq_address    (ioreq_address),
    .ioreq_value      (ioreq_value),
    .ioreq_ack        (ioreq_ack),
    .iorsp_valid      (iorsp_valid),
    .iorsp_core       (iorsp_core),
    .iorsp_thread_idx (iorsp_thread_idx),
    .iorsp_read_value (iorsp_read_value),
    .io_write_en      (io_write_en),
    .io_read_en       (io_read_en),
    .io_address       (io_address),
    .io_write_data    (io_write_data),
    .io_read_data     (io_read_data)
  );

  always #5 clk = ~clk;

  int n_cmp   = 0;
  int n_err   = 0;
  int cyc     = 0;
  int ack_cnt = 0;
  int rsp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @slot %0d: got 0x%08h, want 0x%08h", name, cyc, act, exp);
    end
  endtask

  // Peripheral register contents seen on the bus.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h0000_0080) return 32'h1234_5678;
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_0F0F;
  endfunction

  // ---------------- timeline model ----------------
  // Slot k = the cycle following rising edge k. A request granted at edge k shows
  // its strobe/ack in slot k, a store responds in slot k+1, a load in slot k+2, and
  // the bridge can grant again at edge k+3 (store) or k+4 (load).
  bit [NC-1:0]   exp_ack   [MAXC];
  bit            exp_wr    [MAXC];
  bit            exp_rd    [MAXC];
  bit [31:0]     exp_addr  [MAXC];
  bit [31:0]     exp_wdata [MAXC];
  bit            exp_rv    [MAXC];
  bit [3:0]      exp_rc    [MAXC];
  bit [TIDW-1:0] exp_rt    [MAXC];
  bit [31:0]     exp_rval  [MAXC];

  int            m_rr   = 0;
  int            m_free = 0;
  int            m_g;
  int            m_r;
  logic          m_st;
  logic [31:0]   m_a;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!reset && cyc >= m_free && ioreq_valid != '0 && cyc + 4 < MAXC) begin
      m_g = -1;
      for (int i = 0; i < NC; i++)
        if (m_g < 0 && ioreq_valid[(m_rr + i) % NC]) m_g = (m_rr + i) % NC;
      m_st             = ioreq_store[m_g];
      m_a              = ioreq_address[m_g*32 +: 32];
      exp_ack[cyc]     = 4'b0001 << m_g;
      exp_wr[cyc]      = m_st;
      exp_rd[cyc]      = !m_st;
      exp_addr[cyc]    = m_a;
      exp_wdata[cyc]   = ioreq_value[m_g*32 +: 32];
      m_r              = cyc + (m_st ? 1 : 2);
      exp_rv[m_r]      = 1'b1;
      exp_rc[m_r]      = 4'(m_g);
      exp_rt[m_r]      = ioreq_thread_idx[m_g*TIDW +: TIDW];
      exp_rval[m_r]    = m_st ? 32'h0 : mem_val(m_a);
      m_free           = cyc + (m_st ? 3 : 4);
      m_rr             = (m_g + 1) % NC;
    end
  end

  // Reset abandons everything still scheduled from the current slot onwards.
  initial forever begin
    @(posedge reset);
    for (int s = cyc; s < MAXC; s++) begin
      exp_ack[s] = '0; exp_wr[s] = 1'b0; exp_rd[s] = 1'b0; exp_rv[s] = 1'b0;
    end
    m_rr   = 0;
    m_free = 0;
  end

  // ---------------- compare process ----------------
  initial forever begin
    @(negedge clk);
    if (cyc < MAXC) begin
      check("ack", 32'(ioreq_ack), 32'(exp_ack[cyc]));
      check("write_en", 32'(io_write_en), 32'(exp_wr[cyc]));
      check("read_en", 32'(io_read_en), 32'(exp_rd[cyc]));
      check("strobe_overlap", 32'(io_write_en & io_read_en), 32'h0);
      check("rsp_valid", 32'(iorsp_valid), 32'(exp_rv[cyc]));
      if (exp_wr[cyc] || exp_rd[cyc]) check("address", io_address, exp_addr[cyc]);
      if (exp_wr[cyc]) check("write_data", io_write_data, exp_wdata[cyc]);
      if (exp_rv[cyc]) begin
        check("rsp_core", 32'(iorsp_core), 32'(exp_rc[cyc]));
        check("rsp_thread", 32'(iorsp_thread_idx), 32'(exp_rt[cyc]));
        check("rsp_value", iorsp_read_value, exp_rval[cyc]);
      end
    end
    ack_cnt += $countones(ioreq_ack);
    if (iorsp_valid) rsp_cnt++;
  end

  // ---------------- requesters and bus ----------------
  bit          q_st   [NC][QD];
  logic [1:0]  q_tid  [NC][QD];
  logic [31:0] q_addr [NC][QD];
  logic [31:0] q_val  [NC][QD];
  int          q_nb   [NC][QD];
  int          wp     [NC];
  int          rp     [NC];
  bit          busy   [NC];
  int          waits  [NC];
  logic        prev_rd;
  logic [31:0] prev_addr;

  task automatic push(input int c, input bit st, input logic [1:0] tid,
                      input logic [31:0] a, input logic [31:0] v, input int nb);
    if (wp[c] < QD) begin
      q_st[c][wp[c]]   = st;
      q_tid[c][wp[c]]  = tid;
      q_addr[c][wp[c]] = a;
      q_val[c][wp[c]]  = v;
      q_nb[c][wp[c]]   = nb;
      wp[c]++;
    end
  endtask

  function automatic bit all_done();
    for (int c = 0; c < NC; c++) if (rp[c] != wp[c] || busy[c]) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    ioreq_valid      = '0;
    ioreq_store      = '0;
    ioreq_thread_idx = '0;
    ioreq_address    = '0;
    ioreq_value      = '0;
    io_read_data     = '0;
    prev_rd          = 1'b0;
    prev_addr        = '0;
    for (int c = 0; c < NC; c++) begin wp[c] = 0; rp[c] = 0; busy[c] = 1'b0; waits[c] = 0; end
    forever begin
      @(negedge clk);
      // Bus returns data only in the slot after a read strobe; filler otherwise.
      io_read_data = prev_rd ? mem_val(prev_addr) : (32'hBAD0_0000 | 32'(cyc));
      prev_rd      = io_read_en;
      prev_addr    = io_address;
      for (int c = 0; c < NC; c++) begin
        if (busy[c]) begin
          if (ioreq_ack[c]) begin
            check("rr_wait_bound", 32'(waits[c] <= 3), 32'h1);
            rp[c]++;
            busy[c] = 1'b0;
          end else if (ioreq_ack != '0) begin
            waits[c]++;
          end
        end
      end
      for (int c = 0; c < NC; c++) begin
        if (rp[c] < wp[c] && cyc >= q_nb[c][rp[c]]) begin
          if (!busy[c]) waits[c] = 0;
          busy[c]                          = 1'b1;
          ioreq_valid[c]                   = 1'b1;
          ioreq_store[c]                   = q_st[c][rp[c]];
          ioreq_thread_idx[c*TIDW +: TIDW] = q_tid[c][rp[c]];
          ioreq_address[c*32 +: 32]        = q_addr[c][rp[c]];
          ioreq_value[c*32 +: 32]          = q_val[c][rp[c]];
        end else begin
          busy[c]        = 1'b0;
          ioreq_valid[c] = 1'b0;
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  task automatic wait_ack(output int slot);
    int t;
    slot = -1;
    t    = 0;
    while (slot < 0 && t < 40) begin
      @(negedge clk);
      t++;
      if (ioreq_ack != '0) slot = cyc;
    end
    if (slot < 0) check("ack_timeout", 32'h0, 32'h1);
  endtask

  int p;
  int ka;
  int t;
  int n;
  int rsp_before;
  int rs_slot [5];
  int rs_core [5];
  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset: nothing moves.
    repeat (8) @(negedge clk);
    check("idle_outputs", 32'({ioreq_ack, io_write_en, io_read_en, iorsp_valid}), 32'h0);
    check("idle_address", io_address, 32'h0);

    // Core 0 thread 2 store.
    @(posedge clk); #2;
    p = cyc;
    push(0, 1'b1, 2'd2, 32'h0000_0040, 32'hDEAD_BEEF, p);
    wait_ack(ka);
    check("st_ack_latency", 32'(ka - p), 32'd1);
    check("st_ack", 32'(ioreq_ack), 32'h1);
    check("st_write_en", 32'(io_write_en), 32'h1);
    check("st_read_en", 32'(io_read_en), 32'h0);
    check("st_address", io_address, 32'h0000_0040);
    check("st_write_data", io_write_data, 32'hDEAD_BEEF);
    @(negedge clk);
    check("st_rsp_valid", 32'(iorsp_valid), 32'h1);
    check("st_rsp_core", 32'(iorsp_core), 32'h0);
    check("st_rsp_thread", 32'(iorsp_thread_idx), 32'h2);
    check("st_rsp_value", iorsp_read_value, 32'h0);

    // Core 1 thread 3 load.
    @(posedge clk); #2;
    p = cyc;
    push(1, 1'b0, 2'd3, 32'h0000_0080, 32'h0, p);
    wait_ack(ka);
    check("ld_ack_latency", 32'(ka - p), 32'd1);
    check("ld_ack", 32'(ioreq_ack), 32'h2);
    check("ld_read_en", 32'(io_read_en), 32'h1);
    check("ld_write_en", 32'(io_write_en), 32'h0);
    check("ld_address", io_address, 32'h0000_0080);
    @(negedge clk);
    check("ld_rsp_early", 32'(iorsp_valid), 32'h0);
    @(negedge clk);
    check("ld_rsp_valid", 32'(iorsp_valid), 32'h1);
    check("ld_rsp_core", 32'(iorsp_core), 32'h1);
    check("ld_rsp_thread", 32'(iorsp_thread_idx), 32'h3);
    check("ld_rsp_value", iorsp_read_value, 32'h1234_5678);

    // Reset during the wait-for-read-data cycle of a load from core 2.
    @(posedge clk); #2;
    p = cyc;
    push(2, 1'b0, 2'd1, 32'h0000_0100, 32'h0, p);
    wait_ack(ka);
    check("ab_ack", 32'(ioreq_ack), 32'h4);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    rsp_before = rsp_cnt;
    check("ab_outputs_clear", 32'({ioreq_ack, io_write_en, io_read_en, iorsp_valid}), 32'h0);
    check("ab_address_clear", io_address, 32'h0);
    check("ab_core_clear", 32'(iorsp_core), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(negedge clk);
    check("ab_no_response", 32'(rsp_cnt - rsp_before), 32'h0);

    // Store after reset release completes with normal latency.
    @(posedge clk); #2;
    p = cyc;
    push(3, 1'b1, 2'd1, 32'h0000_0200, 32'hCAFE_F00D, p);
    wait_ack(ka);
    check("pr_ack_latency", 32'(ka - p), 32'd1);
    check("pr_ack", 32'(ioreq_ack), 32'h8);
    check("pr_write_en", 32'(io_write_en), 32'h1);
    check("pr_address", io_address, 32'h0000_0200);
    check("pr_write_data", io_write_data, 32'hCAFE_F00D);
    @(negedge clk);
    check("pr_rsp_valid", 32'(iorsp_valid), 32'h1);
    check("pr_rsp_core", 32'(iorsp_core), 32'h3);
    check("pr_rsp_thread", 32'(iorsp_thread_idx), 32'h1);

    // All four cores load at once; core 0 re-requests right after its ack.
    @(posedge clk); #2;
    p = cyc;
    for (int c = 0; c < NC; c++) push(c, 1'b0, 2'(c), 32'h0000_1000 + 32'(c * 4), 32'h0, p);
    push(0, 1'b0, 2'd3, 32'h0000_2000, 32'h0, p);
    n = 0;
    t = 0;
    while (n < 5 && t < 60) begin
      @(negedge clk);
      t++;
      if (iorsp_valid) begin
        rs_slot[n] = cyc;
        rs_core[n] = int'(iorsp_core);
        n++;
      end
    end
    check("rr_rsp_count", 32'(n), 32'd5);
    check("rr_first_latency", 32'(rs_slot[0] - p), 32'd3);
    for (int j = 0; j < 5; j++) check($sformatf("rr_order_%0d", j), 32'(rs_core[j]), 32'(exp_order[j]));
    for (int j = 1; j < 5; j++) check($sformatf("rr_spacing_%0d", j), 32'(rs_slot[j] - rs_slot[j-1]), 32'd4);

    // Mixed stores and loads from all cores.
    repeat (4) @(negedge clk);
    @(posedge clk); #2;
    p = cyc;
    for (int i = 0; i < 40; i++)
      push(int'($urandom_range(0, NC - 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           $urandom & 32'hFFFF_FFFC, $urandom, p + int'($urandom_range(0, 100)));
    t = 0;
    while (!all_done() && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_done", 32'(all_done()), 32'h1);
    repeat (6) @(negedge clk);
    check("total_acks", 32'(ack_cnt), 32'd49);
    check("total_responses", 32'(rsp_cnt), 32'd48);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
